i2s_sample_rx: RTL and testbench

//  Upstream source for the lowpass FIR: deserialises one channel of an external I2S stream into
//  18-bit two's-complement samples and emits a one-cycle endata strobe per captured sample.

---
 rtl/i2s_sample_rx_pkg.sv | 16 +
 rtl/i2s_sample_rx_sync_edge_det.sv | 43 ++++
 rtl/i2s_sample_rx.sv | 145 ++++++++++++++
 tb/tb_i2s_sample_rx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_sample_rx_pkg.sv
// rtl/i2s_sample_rx_pkg.sv - shared constants and state encoding for the I2S sample receiver
package i2s_sample_rx_pkg;

    localparam int DATA_W_DEF    = 18;
    localparam int SLOT_W_DEF    = 32;
    localparam int I2S_SKIP_BITS = 1;
    localparam int CNT_W         = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/i2s_sample_rx_sync_edge_det.sv
// rtl/i2s_sample_rx_sync_edge_det.sv - input synchroniser with registered edge pulse and aligned level
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic edge_det
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic [STAGES:0]   vld_q, vld_d;
    logic              prev_q, prev_d;
    logic              edge_q, edge_d;

    // vld gates the edge pulse until the chain holds real samples, so the
    // first value seen after reset never looks like an edge.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        vld_d  = {vld_q[STAGES-1:0], 1'b1};
        prev_d = sync_q[STAGES-1];
        edge_d = vld_q[STAGES] & (sync_q[STAGES-1] ^ prev_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            vld_q  <= '0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            vld_q  <= vld_d;
            prev_q <= prev_d;
            edge_q <= edge_d;
        end
    end

    assign level    = prev_q;
    assign edge_det = edge_q;

endmodule

// File: rtl/i2s_sample_rx.sv
// rtl/i2s_sample_rx.sv - one-channel I2S deserialiser delivering DATA_W-bit samples with a strobe
module i2s_sample_rx
    import i2s_sample_rx_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SLOT_W      = SLOT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              chan_sel,
    input  logic              bclk_in,
    input  logic              lrclk_in,
    input  logic              sdata_in,
    output logic [DATA_W-1:0] dataout,
    output logic              endata,
    output logic              frame_err,
    output logic [CNT_W-1:0]  bit_cnt_dbg
);

    if (SYNC_STAGES < 2 || SLOT_W < DATA_W || SLOT_W > 64) begin : g_param_check
        $error("i2s_sample_rx: illegal SYNC_STAGES/SLOT_W/DATA_W combination");
    end

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(I2S_SKIP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam bit               ONE_SKIP  = (I2S_SKIP_BITS == 1);

    logic bclk_level, bclk_edge, lr_level, lr_edge;
    logic brise, sel_now, new_slot, sdata_al;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_bclk_sync (
        .clock(clock), .reset(reset), .din(bclk_in), .level(bclk_level), .edge_det(bclk_edge)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_lrclk_sync (
        .clock(clock), .reset(reset), .din(lrclk_in), .level(lr_level), .edge_det(lr_edge)
    );

    // One flop deeper than the plain synchroniser to line up with the registered edge pulses.
    logic [SYNC_STAGES:0] sdata_q, sdata_d;
    assign sdata_d  = {sdata_q[SYNC_STAGES-1:0], sdata_in};
    assign sdata_al = sdata_q[SYNC_STAGES];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d, shifted;
    logic [DATA_W-1:0] dataout_q, dataout_d;
    logic              endata_q, endata_d;
    logic              frame_err_q, frame_err_d;
    logic              sel_q, sel_d;

    assign brise    = bclk_edge & bclk_level;
    assign sel_now  = (state_q == IDLE) ? chan_sel : sel_q;
    assign new_slot = lr_edge & (lr_level == sel_now);
    assign shifted  = {shift_q[DATA_W-2:0], sdata_al};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        dataout_d   = dataout_q;
        endata_d    = 1'b0;
        frame_err_d = 1'b0;
        sel_d       = (state_q == IDLE) ? chan_sel : sel_q;

        // An lrclk edge wins over a coincident brise; that brise is then the skip bit.
        if (lr_edge) begin
            frame_err_d = (state_q == SKIP) || (state_q == SHIFT);
            cnt_d       = '0;
            shift_d     = '0;
            if (!new_slot) begin
                state_d = IDLE;
            end else if (brise && ONE_SKIP) begin
                state_d = SHIFT;
            end else begin
                state_d = SKIP;
                if (brise) cnt_d = CNT_W'(1);
            end
        end else if (brise) begin
            case (state_q)
                SKIP: begin
                    if (cnt_q == SKIP_LAST) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    shift_d = shifted;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        dataout_d = shifted;
                        endata_d  = 1'b1;
                        state_d   = DRAIN;
                    end
                end
                DRAIN: begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end

        if (!enable) begin
            state_d     = IDLE;
            cnt_d       = '0;
            shift_d     = '0;
            dataout_d   = '0;
            endata_d    = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            dataout_q   <= '0;
            endata_q    <= 1'b0;
            frame_err_q <= 1'b0;
            sel_q       <= 1'b0;
            sdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            dataout_q   <= dataout_d;
            endata_q    <= endata_d;
            frame_err_q <= frame_err_d;
            sel_q       <= sel_d;
            sdata_q     <= sdata_d;
        end
    end

    assign dataout     = dataout_q;
    assign endata      = endata_q;
    assign frame_err   = frame_err_q;
    assign bit_cnt_dbg = cnt_q;

endmodule

// File: tb/tb_i2s_sample_rx.sv
// tb/tb_i2s_sample_rx.sv - scoreboard bench for i2s_sample_rx
module tb_i2s_sample_rx;

    localparam int DW = 18;
    localparam int SW = 32;
    localparam int SS = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          chan_sel = 1'b0;
    logic          bclk_in = 1'b0;
    logic          lrclk_in = 1'b1;
    logic          sdata_in = 1'b0;
    logic [DW-1:0] dataout;
    logic          endata;
    logic          frame_err;
    logic [5:0]    bit_cnt_dbg;

    i2s_sample_rx #(.DATA_W(DW), .SLOT_W(SW), .SYNC_STAGES(SS)) dut (
        .clock(clock), .reset(reset), .enable(enable), .chan_sel(chan_sel),
        .bclk_in(bclk_in), .lrclk_in(lrclk_in), .sdata_in(sdata_in),
        .dataout(dataout), .endata(endata), .frame_err(frame_err), .bit_cnt_dbg(bit_cnt_dbg)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    int            n_strobe = 0;
    int            fe_count = 0;
    int            last_strobe_cyc = 0;
    int            rise_cyc = 0;
    bit            spacing_en = 1'b0;
    bit            have_prev = 1'b0;
    logic          prev_en = 1'b0;
    logic          prev_fe = 1'b0;
    logic          last_bit = 1'b0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_monitor();
        logic [DW-1:0] exp;
        forever begin
            @(negedge clock);
            if (endata === 1'b1) begin
                n_strobe++;
                checks++;
                if (prev_en === 1'b1) begin
                    errors++;
                    $display("FAIL endata_single: endata high two cycles in a row, required one");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: dataout=%h, required no strobe", dataout);
                end else begin
                    exp = exp_q.pop_front();
                    if (dataout !== exp) begin
                        errors++;
                        $display("FAIL sample: dataout=%h, required %h", dataout, exp);
                    end
                end
                if (spacing_en) begin
                    if (have_prev) begin
                        checks++;
                        if (cyc - last_strobe_cyc != 2 * SW * 4) begin
                            errors++;
                            $display("FAIL strobe_spacing: %0d clocks, required %0d", cyc - last_strobe_cyc, 2 * SW * 4);
                        end
                    end
                    have_prev = 1'b1;
                end
                last_strobe_cyc = cyc;
            end
            if (frame_err === 1'b1) begin
                fe_count++;
                checks++;
                if (prev_fe === 1'b1) begin
                    errors++;
                    $display("FAIL frame_err_single: frame_err high two cycles in a row, required one");
                end
            end
            prev_en = endata;
            prev_fe = frame_err;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        tick();
    endtask

    function automatic logic [63:0] mk(input logic [DW-1:0] w, input logic [63:0] fill);
        return {w, fill[63-DW:0]};
    endfunction

    // act: 1 = reset pulse, 2 = enable off, 3 = enable on, applied at bit act_at
    task automatic send_slot(input logic lvl, input logic [63:0] sv, input int nbits,
                             input int h, input int act_at, input int act);
        for (int j = 0; j < nbits; j++) begin
            bclk_in = 1'b0;
            if (j == 0) lrclk_in = lvl;
            sdata_in = (j == 0) ? last_bit : sv[64-j];
            if (j == act_at) begin
                case (act)
                    1: begin reset = 1'b1; repeat (3) tick(); reset = 1'b0; end
                    2: enable = 1'b0;
                    3: enable = 1'b1;
                    default: ;
                endcase
            end
            repeat (h) tick();
            bclk_in = 1'b1;
            if (j == DW) rise_cyc = cyc;
            repeat (h) tick();
        end
        last_bit = sv[64-nbits];
    endtask

    task automatic send_rand(input logic lvl, input int h);
        send_slot(lvl, {$urandom, $urandom}, SW, h, -1, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dataout !== '0)     begin errors++; $display("FAIL reset_dataout: %h, required 0", dataout); end
        checks++; if (endata !== 1'b0)    begin errors++; $display("FAIL reset_endata: %b, required 0", endata); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: %b, required 0", frame_err); end
        checks++; if (bit_cnt_dbg !== '0) begin errors++; $display("FAIL reset_bit_cnt: %0d, required 0", bit_cnt_dbg); end
    endtask

    task automatic test_basic();
        int s0, f0;
        do_reset();
        s0 = n_strobe; f0 = fe_count;
        exp_q.push_back(18'h2A5C3);
        send_slot(1'b0, mk(18'h2A5C3, '1), SW, 4, -1, 0);
        checks++;
        if (last_strobe_cyc - rise_cyc != SS + 2) begin
            errors++; $display("FAIL latency: %0d clocks, required %0d", last_strobe_cyc - rise_cyc, SS + 2);
        end
        send_slot(1'b1, mk(18'h15555, 64'h0), SW, 4, -1, 0);
        checks++; if (dataout !== 18'h2A5C3) begin errors++; $display("FAIL basic_hold: %h, required 2a5c3", dataout); end
        checks++; if (n_strobe - s0 != 1)    begin errors++; $display("FAIL basic_strobes: %0d, required 1", n_strobe - s0); end
        checks++; if (fe_count != f0)        begin errors++; $display("FAIL basic_frame_err: %0d, required 0", fe_count - f0); end
        checks++; if (exp_q.size() != 0)     begin errors++; $display("FAIL basic_pending: %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_right_channel();
        int s0, f0;
        chan_sel = 1'b1;
        do_reset();
        s0 = n_strobe; f0 = fe_count;
        for (int f = 0; f < 4; f++) begin
            exp_q.push_back(18'h3FFFF);
            send_slot(1'b0, mk(18'h00001, {$urandom, $urandom}), SW, 4, -1, 0);
            send_slot(1'b1, mk(18'h3FFFF, {$urandom, $urandom}), SW, 4, -1, 0);
        end
        repeat (8) tick();
        checks++; if (n_strobe - s0 != 4)    begin errors++; $display("FAIL right_strobes: %0d, required 4", n_strobe - s0); end
        checks++; if (dataout !== 18'h3FFFF) begin errors++; $display("FAIL right_data: %h, required 3ffff", dataout); end
        checks++; if (fe_count != f0)        begin errors++; $display("FAIL right_frame_err: %0d, required 0", fe_count - f0); end
        checks++; if (exp_q.size() != 0)     begin errors++; $display("FAIL right_pending: %0d, required 0", exp_q.size()); end
        chan_sel = 1'b0;
    endtask

    task automatic test_short_slot();
        int s0, f0;
        do_reset();
        s0 = n_strobe; f0 = fe_count;
        exp_q.push_back(18'h12345);
        send_slot(1'b0, mk(18'h12345, {$urandom, $urandom}), SW, 4, -1, 0);
        send_rand(1'b1, 4);
        send_slot(1'b0, mk(18'h0BEEF, {$urandom, $urandom}), 10, 4, -1, 0);
        send_rand(1'b1, 4);
        checks++; if (fe_count - f0 != 1)    begin errors++; $display("FAIL short_frame_err: %0d pulses, required 1", fe_count - f0); end
        checks++; if (dataout !== 18'h12345) begin errors++; $display("FAIL short_hold: %h, required 12345", dataout); end
        checks++; if (n_strobe - s0 != 1)    begin errors++; $display("FAIL short_strobes: %0d, required 1", n_strobe - s0); end
        exp_q.push_back(18'h20F0F);
        send_slot(1'b0, mk(18'h20F0F, {$urandom, $urandom}), SW, 4, -1, 0);
        send_rand(1'b1, 4);
        checks++; if (dataout !== 18'h20F0F) begin errors++; $display("FAIL short_next: %h, required 20f0f", dataout); end
        checks++; if (exp_q.size() != 0)     begin errors++; $display("FAIL short_pending: %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_slot();
        int s0;
        do_reset();
        s0 = n_strobe;
        exp_q.push_back(18'h3C3C3);
        send_slot(1'b0, mk(18'h3C3C3, {$urandom, $urandom}), SW, 4, -1, 0);
        send_rand(1'b1, 4);
        send_slot(1'b0, mk(18'h11111, {$urandom, $urandom}), SW, 4, 9, 1);
        checks++; if (dataout !== '0) begin errors++; $display("FAIL midreset_data: %h, required 0", dataout); end
        send_rand(1'b1, 4);
        exp_q.push_back(18'h05A5A);
        send_slot(1'b0, mk(18'h05A5A, {$urandom, $urandom}), SW, 4, -1, 0);
        send_rand(1'b1, 4);
        checks++; if (n_strobe - s0 != 2)    begin errors++; $display("FAIL midreset_strobes: %0d, required 2", n_strobe - s0); end
        checks++; if (dataout !== 18'h05A5A) begin errors++; $display("FAIL midreset_next: %h, required 05a5a", dataout); end
        checks++; if (exp_q.size() != 0)     begin errors++; $display("FAIL midreset_pending: %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_enable();
        int s0, f0;
        lrclk_in = 1'b0;
        do_reset();
        s0 = n_strobe; f0 = fe_count;
        send_slot(1'b0, {$urandom, $urandom}, 20, 4, -1, 0);
        send_rand(1'b1, 4);
        exp_q.push_back(18'h2B1E4);
        send_slot(1'b0, mk(18'h2B1E4, {$urandom, $urandom}), SW, 4, -1, 0);
        send_rand(1'b1, 4);
        checks++; if (dataout !== 18'h2B1E4) begin errors++; $display("FAIL enable_first: %h, required 2b1e4", dataout); end
        send_slot(1'b0, mk(18'h1F00F, {$urandom, $urandom}), SW, 4, 5, 2);
        checks++; if (dataout !== '0) begin errors++; $display("FAIL enable_off_data: %h, required 0", dataout); end
        for (int f = 0; f < 2; f++) begin
            send_rand(1'b1, 4);
            send_rand(1'b0, 4);
        end
        send_rand(1'b1, 4);
        send_slot(1'b0, mk(18'h0CAFE, {$urandom, $urandom}), SW, 4, 25, 3);
        send_rand(1'b1, 4);
        checks++; if (n_strobe - s0 != 1) begin errors++; $display("FAIL enable_partial: %0d strobes, required 1", n_strobe - s0); end
        exp_q.push_back(18'h3A0C5);
        send_slot(1'b0, mk(18'h3A0C5, {$urandom, $urandom}), SW, 4, -1, 0);
        send_rand(1'b1, 4);
        checks++; if (n_strobe - s0 != 2)    begin errors++; $display("FAIL enable_strobes: %0d, required 2", n_strobe - s0); end
        checks++; if (dataout !== 18'h3A0C5) begin errors++; $display("FAIL enable_last: %h, required 3a0c5", dataout); end
        checks++; if (fe_count != f0)        begin errors++; $display("FAIL enable_frame_err: %0d, required 0", fe_count - f0); end
        checks++; if (exp_q.size() != 0)     begin errors++; $display("FAIL enable_pending: %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int s0, f0;
        logic [DW-1:0] l_word;
        lrclk_in = 1'b1;
        do_reset();
        s0 = n_strobe; f0 = fe_count;
        have_prev  = 1'b0;
        spacing_en = 1'b1;
        for (int f = 0; f < 150; f++) begin
            l_word = DW'($urandom);
            exp_q.push_back(l_word);
            send_slot(1'b0, mk(l_word, {$urandom, $urandom}), SW, 2, -1, 0);
            send_rand(1'b1, 2);
        end
        spacing_en = 1'b0;
        checks++; if (n_strobe - s0 != 150) begin errors++; $display("FAIL b2b_strobes: %0d, required 150", n_strobe - s0); end
        checks++; if (fe_count != f0)       begin errors++; $display("FAIL b2b_frame_err: %0d, required 0", fe_count - f0); end
        checks++; if (exp_q.size() != 0)    begin errors++; $display("FAIL b2b_pending: %0d, required 0", exp_q.size()); end
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_basic();
        test_right_channel();
        test_short_slot();
        test_reset_mid_slot();
        test_enable();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
